// File: rtl/approx_mul_rr_sched.sv
// Round-robin front end for a shared 8x8 approximate multiplier array, with two-stage reduction pipeline.
// Optional performance counters are enabled by defining APPROX_MUL_PERF_CNT_EN.
module approx_mul_rr_sched #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_x,
    input  logic [8*NREQ-1:0] req_y,
    output logic [7:0]        mul_x,
    output logic [7:0]        mul_y,
    input  logic [27:0]       arr_b,
    input  logic [35:0]       arr_t,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [15:0]       rsp_p
`ifdef APPROX_MUL_PERF_CNT_EN
    ,
    output logic [31:0]       perf_issue_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    logic            p1_valid_q, p1_valid_d;
    logic [27:0]     p1_b_q, p1_b_d;
    logic [35:0]     p1_t_q, p1_t_d;
    logic [ID_W-1:0] p1_id_q, p1_id_d;
    logic            p2_valid_q, p2_valid_d;
    logic [ID_W-1:0] p2_id_q, p2_id_d;
    logic [15:0]     p2_p_q, p2_p_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic            p1_adv, issue_ok;
    logic            found;
    logic [ID_W-1:0] gnt_id;
    logic            gnt;

    function automatic logic [15:0] reduce(input logic [27:0] b,
                                           input logic [35:0] t);
        logic [17:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            s = s + (18'(t[9*k +: 9]) << (2*k));
            s = s + (18'(b[7*k +: 7]) << (2*k + 2));
        end
        return s[15:0];
    endfunction

    assign p1_adv   = !p2_valid_q || rsp_ready;
    assign issue_ok = !p1_valid_q || p1_adv;

    // Two passes: indices at/after the pointer first, then the wrapped ones.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && ID_W'(i) >= rr_ptr_q) begin
                found  = 1'b1;
                gnt_id = ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && ID_W'(i) < rr_ptr_q) begin
                found  = 1'b1;
                gnt_id = ID_W'(i);
            end
        end
    end

    assign gnt = found && issue_ok && rst_n;

    always_comb begin
        req_ready = '0;
        mul_x     = 8'h00;
        mul_y     = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt && gnt_id == ID_W'(i)) begin
                req_ready[i] = 1'b1;
                mul_x        = req_x[8*i +: 8];
                mul_y        = req_y[8*i +: 8];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt) begin
            rr_ptr_d = (gnt_id == ID_W'(NREQ-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_comb begin
        p1_valid_d = issue_ok ? gnt : p1_valid_q;
        p1_b_d     = gnt ? arr_b  : p1_b_q;
        p1_t_d     = gnt ? arr_t  : p1_t_q;
        p1_id_d    = gnt ? gnt_id : p1_id_q;
    end

    always_comb begin
        p2_valid_d = p1_adv ? p1_valid_q : p2_valid_q;
        p2_id_d    = p2_id_q;
        p2_p_d     = p2_p_q;
        if (p1_adv && p1_valid_q) begin
            p2_id_d = p1_id_q;
            p2_p_d  = reduce(p1_b_q, p1_t_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid_q <= 1'b0;
            p1_b_q     <= '0;
            p1_t_q     <= '0;
            p1_id_q    <= '0;
            p2_valid_q <= 1'b0;
            p2_id_q    <= '0;
            p2_p_q     <= '0;
            rr_ptr_q   <= '0;
        end else begin
            p1_valid_q <= p1_valid_d;
            p1_b_q     <= p1_b_d;
            p1_t_q     <= p1_t_d;
            p1_id_q    <= p1_id_d;
            p2_valid_q <= p2_valid_d;
            p2_id_q    <= p2_id_d;
            p2_p_q     <= p2_p_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign rsp_valid = p2_valid_q;
    assign rsp_id    = p2_id_q;
    assign rsp_p     = p2_p_q;

`ifdef APPROX_MUL_PERF_CNT_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q + {31'd0, gnt};
        stall_cnt_d = stall_cnt_q + {31'd0, (p2_valid_q && !rsp_ready)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_issue_cnt = issue_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
